// File: rtl/irs_ps_responder_pkg.sv
// irs_ps_responder_pkg: shared phase-shift constants, FSM encoding and limit helper
package irs_ps_responder_pkg;
  localparam int PS_LATENCY_DEF = 4;
  localparam int PHASE_MAX_DEF = 255;
  localparam int LOCK_EDGES_DEF = 3;
  localparam int PHASE_W = 9;
  typedef enum logic [1:0] {
    PS_IDLE       = 2'd0,
    PS_SHIFT_WAIT = 2'd1,
    PS_DONE       = 2'd2
  } ps_state_e;
  function automatic logic at_limit(logic [PHASE_W-1:0] p, logic inc, int pmax);
    return inc ? p == PHASE_W'(pmax) : p == PHASE_W'(-pmax);
  endfunction
endpackage

// File: rtl/irs_ps_strobe_delay.sv
// irs_ps_strobe_delay: strobe rising-edge detect and phase-dependent delayed pulse
module irs_ps_strobe_delay
  import irs_ps_responder_pkg::*;
#(
  parameter int PHASE_MAX = PHASE_MAX_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               strobe_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic               rise_o,
  output logic               strobe_delayed_o
);
  localparam int DW = PHASE_W + 1;
  logic          strobe_q, pend_q, pend_d, pulse_q, pulse_d;
  logic [DW-1:0] cnt_q, cnt_d;
  // A fresh edge always reloads the count, which also aborts a pending pulse
  always_comb begin
    rise_o  = strobe_i & ~strobe_q;
    pulse_d = pend_q && cnt_q == '0 && !rise_o;
    pend_d  = rise_o || (pend_q && cnt_q != '0);
    cnt_d   = rise_o ? {phase_i[PHASE_W-1], phase_i} + DW'(PHASE_MAX)
            : (pend_q && cnt_q != '0) ? cnt_q - DW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      strobe_q <= 1'b0;
      pend_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      strobe_q <= strobe_i;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  assign strobe_delayed_o = pulse_q;
endmodule

// File: rtl/irs_ps_responder.sv
// irs_ps_responder: PSEN/PSINCDEC/PSDONE responder with phase register and strobe lock
module irs_ps_responder
  import irs_ps_responder_pkg::*;
#(
  parameter int PS_LATENCY = PS_LATENCY_DEF,
  parameter int PHASE_MAX  = PHASE_MAX_DEF,
  parameter int LOCK_EDGES = LOCK_EDGES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               psen_i,
  input  logic               psincdec_i,
  output logic               psdone_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic [7:0]         status_o,
  output logic               locked_o,
  input  logic               strobe_i,
  output logic               strobe_delayed_o
);
  localparam int CW = $clog2(PS_LATENCY + 1);
  localparam int EW = $clog2(LOCK_EDGES + 1);
  ps_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]      ecnt_q, ecnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               dir_q, dir_d, done_q, done_d, ovf_q, ovf_d, lim, rise;
  irs_ps_strobe_delay #(.PHASE_MAX(PHASE_MAX)) u_dly (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .strobe_i        (strobe_i),
    .phase_i         (phase_q),
    .rise_o          (rise),
    .strobe_delayed_o(strobe_delayed_o)
  );
  assign locked_o = ecnt_q == EW'(LOCK_EDGES);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    phase_d = phase_q;
    ovf_d   = ovf_q;
    lim     = at_limit(phase_q, dir_q, PHASE_MAX);
    ecnt_d  = (rise && !locked_o) ? ecnt_q + EW'(1) : ecnt_q;
    case (state_q)
      PS_IDLE:
        if (psen_i && locked_o) begin
          state_d = PS_SHIFT_WAIT;
          cnt_d   = CW'(PS_LATENCY - 1);
          dir_d   = psincdec_i;
        end
      PS_SHIFT_WAIT:
        if (cnt_q == '0) begin
          state_d = PS_DONE;
          done_d  = 1'b1;
          ovf_d   = lim;
          phase_d = lim ? phase_q : dir_q ? phase_q + PHASE_W'(1) : phase_q - PHASE_W'(1);
        end else cnt_d = cnt_q - CW'(1);
      default: state_d = PS_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      phase_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  assign psdone_o = done_q;
  assign phase_o  = phase_q;
  assign status_o = {7'b0, ovf_q};
endmodule

// File: tb/tb_irs_ps_responder.sv
// tb_irs_ps_responder: directed stimulus with a cycle-scheduled reference model
module tb_irs_ps_responder;
  localparam int LAT = 4;
  localparam int PMAX = 255;
  localparam int LE = 3;
  logic clk = 0, rst, psen, psincdec, strobe;
  logic psdone_o, locked_o, strobe_delayed_o;
  logic [8:0] phase_o;
  logic [7:0] status_o;
  int checks = 0, failures = 0;
  int cyc = 0, chk_en = 0;
  int m_edges, m_phase, m_ovf, m_done, m_sd, m_prev, m_fire, m_busy, m_idle_from, m_dir, rise;
  int done_cnt = 0, sd_cnt = 0, last_done = -1, last_sd = -1;
  int t, n, d0, s0;

  irs_ps_responder dut (
    .clk_i(clk), .rst_i(rst), .psen_i(psen), .psincdec_i(psincdec),
    .psdone_o(psdone_o), .phase_o(phase_o), .status_o(status_o),
    .locked_o(locked_o), .strobe_i(strobe), .strobe_delayed_o(strobe_delayed_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: shifts and delayed pulses are scheduled as absolute cycle numbers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0; m_phase = 0; m_ovf = 0; m_done = 0; m_sd = 0; m_prev = 0;
      m_fire = -1; m_busy = -1; m_idle_from = 0; m_dir = 0;
    end else begin
      cyc++;
      rise = (strobe && !m_prev) ? 1 : 0;
      m_prev = strobe ? 1 : 0;
      m_sd = (m_fire == cyc && rise == 0) ? 1 : 0;
      if (m_fire == cyc) m_fire = -1;
      if (rise != 0) m_fire = cyc + 1 + m_phase + PMAX;
      m_done = (m_busy == cyc) ? 1 : 0;
      if (m_done != 0) begin
        if (m_dir != 0 ? m_phase == PMAX : m_phase == -PMAX) m_ovf = 1;
        else begin
          m_phase += (m_dir != 0) ? 1 : -1;
          m_ovf = 0;
        end
        m_busy = -1;
        m_idle_from = cyc + 2;
      end else if (psen && m_edges == LE && m_busy < 0 && cyc >= m_idle_from) begin
        m_busy = cyc + LAT;
        m_dir = psincdec ? 1 : 0;
      end
      if (rise != 0 && m_edges < LE) m_edges++;
    end
  end

  always @(negedge clk) if (chk_en != 0) begin
    check("psdone", int'(psdone_o), m_done);
    check("phase", int'($signed(phase_o)), m_phase);
    check("status", int'(status_o), m_ovf);
    check("locked", int'(locked_o), (m_edges == LE) ? 1 : 0);
    check("strobe_delayed", int'(strobe_delayed_o), m_sd);
    if (psdone_o) begin done_cnt++; last_done = cyc; end
    if (strobe_delayed_o) begin sd_cnt++; last_sd = cyc; end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_psen(input logic dir);
    psen = 1; psincdec = dir;
    step(1);
    psen = 0;
  endtask

  task automatic do_shift(input logic dir);
    pulse_psen(dir);
    step(6);
  endtask

  task automatic strobe_edge();
    strobe = 1;
    step(1);
    strobe = 0;
    step(1);
  endtask

  initial begin
    rst = 1; psen = 0; psincdec = 0; strobe = 0;
    step(3);
    rst = 0; chk_en = 1;
    step(1);
    check("rst_phase", int'(phase_o), 0);
    check("rst_status", int'(status_o), 0);
    check("rst_locked", int'(locked_o), 0);
    check("rst_psdone", int'(psdone_o), 0);
    check("rst_sd", int'(strobe_delayed_o), 0);
    do_shift(1);
    check("prelock_done_cnt", done_cnt, 0);
    check("prelock_phase", int'(phase_o), 0);
    repeat (3) strobe_edge();
    check("locked_after_3", int'(locked_o), 1);
    step(300);
    d0 = done_cnt;
    pulse_psen(1);
    t = cyc;
    step(1);
    pulse_psen(1);
    step(6);
    check("first_done_cycle", last_done, t + 4);
    check("first_done_count", done_cnt - d0, 1);
    check("first_phase", int'($signed(phase_o)), 1);
    repeat (254) do_shift(1);
    check("max_phase", int'($signed(phase_o)), 255);
    check("max_status", int'(status_o), 0);
    d0 = done_cnt;
    do_shift(1);
    check("ovf_phase", int'($signed(phase_o)), 255);
    check("ovf_status", int'(status_o), 1);
    check("ovf_done", done_cnt - d0, 1);
    psen = 1; psincdec = 0;
    step(1);
    psen = 0; psincdec = 1;
    step(6);
    check("dec_phase", int'($signed(phase_o)), 254);
    check("dec_status", int'(status_o), 0);
    repeat (509) do_shift(0);
    check("min_phase", int'($signed(phase_o)), -255);
    do_shift(0);
    check("min_ovf_phase", int'($signed(phase_o)), -255);
    check("min_ovf_status", int'(status_o), 1);
    strobe = 1;
    step(1);
    strobe = 0;
    n = cyc;
    step(3);
    check("sd_min_cycle", last_sd, n + 1);
    repeat (255) do_shift(1);
    check("zero_phase", int'($signed(phase_o)), 0);
    s0 = sd_cnt;
    strobe = 1;
    step(1);
    strobe = 0;
    n = cyc;
    step(99);
    strobe = 1;
    step(1);
    strobe = 0;
    step(300);
    check("sd_restart_cycle", last_sd, n + 356);
    check("sd_restart_count", sd_cnt - s0, 1);
    d0 = done_cnt; s0 = sd_cnt;
    strobe = 1;
    pulse_psen(1);
    strobe = 0;
    step(1);
    #1 rst = 1;
    #1;
    check("rstmid_phase", int'(phase_o), 0);
    check("rstmid_locked", int'(locked_o), 0);
    check("rstmid_psdone", int'(psdone_o), 0);
    step(2);
    rst = 0;
    step(600);
    check("post_rst_done", done_cnt - d0, 0);
    check("post_rst_sd", sd_cnt - s0, 0);
    check("post_rst_phase", int'(phase_o), 0);
    strobe_edge();
    strobe_edge();
    do_shift(1);
    check("two_edges_locked", int'(locked_o), 0);
    check("two_edges_phase", int'(phase_o), 0);
    strobe_edge();
    check("relock", int'(locked_o), 1);
    step(600);
    do_shift(0);
    check("relock_phase", int'($signed(phase_o)), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
